clz_unsigned_divider: RTL and testbench

Parametrised iterative unsigned divider behind the requester side of the unsigned division interface. It serves the integer divide unit now and any wider datapath later. It uses the supplied leading-zero counts to skip the iterations that cannot produce quotient bits, so latency scales with the operand magnitude gap instead of being fixed at DATA_WIDTH. It adds early-out paths, abort, and back-to-back issue.

---
 rtl/clz_unsigned_divider.sv | 114 +++++++++++
 tb/tb_clz_unsigned_divider.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clz_unsigned_divider.sv
// Iterative restoring unsigned divider; leading-zero counts trim the iteration count to shift+1.
// Latency 1 cycle for early-outs, shift+2 otherwise; start is ignored (not queued) while busy, abort flushes.
module clz_unsigned_divider #(
    parameter  int DATA_WIDTH = 32,
    localparam int CLZ_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [CLZ_W-1:0]      i_dividend_CLZ,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    input  logic [CLZ_W-1:0]      i_divisor_CLZ,
    input  logic                  i_divisor_is_zero,
    input  logic                  i_abort,
    output logic                  o_ready,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_quotient,
    output logic [DATA_WIDTH-1:0] o_remainder
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_d;
    logic [CLZ_W-1:0]      r_count;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_needs_run;
    logic [CLZ_W-1:0]      w_shift;
    logic                  w_borrow;
    logic [DATA_WIDTH-1:0] w_diff;

    assign w_accept    = i_start & o_ready & ~i_abort & ~i_rst;
    assign w_needs_run = ~i_divisor_is_zero & (i_dividend != '0) &
                         (i_divisor_CLZ >= i_dividend_CLZ);
    assign w_shift     = i_divisor_CLZ - i_dividend_CLZ;

    // Single subtractor: the borrow out doubles as the rem < d comparison.
    assign {w_borrow, w_diff} = {1'b0, r_rem} - {1'b0, r_d};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_needs_run) w_next_state = S_RUN;
            S_RUN:  if (i_abort || r_count == '0) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (r_state == S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q     <= '0;
            r_rem   <= '0;
            r_d     <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_count <= '0;
            end else if (w_accept) begin
                if (i_divisor_is_zero) begin
                    r_q    <= '1;
                    r_rem  <= i_dividend;
                    r_done <= 1'b1;
                end else if (i_dividend == '0) begin
                    r_q    <= '0;
                    r_rem  <= '0;
                    r_done <= 1'b1;
                end else if (i_divisor_CLZ < i_dividend_CLZ) begin
                    r_q    <= '0;
                    r_rem  <= i_dividend;
                    r_done <= 1'b1;
                end else begin
                    r_q     <= '0;
                    r_rem   <= i_dividend;
                    r_d     <= i_divisor << w_shift;
                    r_count <= w_shift;
                end
            end else if (r_state == S_RUN) begin
                if (!w_borrow) r_rem <= w_diff;
                r_q <= {r_q[DATA_WIDTH-2:0], ~w_borrow};
                r_d <= r_d >> 1;
                if (r_count == '0) begin
                    r_done <= 1'b1;
                end else begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    assign o_done      = r_done;
    assign o_quotient  = r_q;
    assign o_remainder = r_rem;

endmodule

// File: tb/tb_clz_unsigned_divider.sv
// Directed and random checks of clz_unsigned_divider results, latency, abort and reset.
module tb_clz_unsigned_divider;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [31:0] i_dividend = '0;
    logic [4:0]  i_dividend_CLZ = '0;
    logic [31:0] i_divisor = '0;
    logic [4:0]  i_divisor_CLZ = '0;
    logic        i_divisor_is_zero = 1'b0;
    logic        i_abort = 1'b0;
    logic        o_ready;
    logic        o_done;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;

    int n_checks = 0;
    int n_fails  = 0;

    clz_unsigned_divider #(.DATA_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_dividend(i_dividend), .i_dividend_CLZ(i_dividend_CLZ),
        .i_divisor(i_divisor), .i_divisor_CLZ(i_divisor_CLZ),
        .i_divisor_is_zero(i_divisor_is_zero), .i_abort(i_abort),
        .o_ready(o_ready), .o_done(o_done),
        .o_quotient(o_quotient), .o_remainder(o_remainder)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [4:0] clz(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) if (v[i]) return 5'(31 - i);
        return 5'd0;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        i_dividend        = a;
        i_dividend_CLZ    = clz(a);
        i_divisor         = b;
        i_divisor_CLZ     = clz(b);
        i_divisor_is_zero = (b == 0);
    endtask

    // Issues one op; returns cycles from accept to done (40 = timed out).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                          output logic [31:0] q, output logic [31:0] r, output int ready_bad);
        set_ops(a, b);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        set_ops(~a, b ^ 32'h5a5a_0f0f);
        lat = 1;
        ready_bad = 0;
        while (!o_done && lat < 40) begin
            if (o_ready !== 1'b0) ready_bad++;
            tick();
            lat++;
        end
        q = o_quotient;
        r = o_remainder;
    endtask

    task automatic count_dones(input int cycles, output int dones);
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            if (o_done) dones++;
            tick();
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_start = 1'b1;
        set_ops(32'd100, 32'd7);
        tick();
        tick();
        i_rst = 1'b0;
        i_start = 1'b0;
        n_checks++; if (o_ready !== 1'b1) begin n_fails++; $display("FAIL reset_ready got %b exp 1", o_ready); end
        n_checks++; if (o_done !== 1'b0) begin n_fails++; $display("FAIL reset_done got %b exp 0", o_done); end
        n_checks++; if (o_quotient !== 32'h0) begin n_fails++; $display("FAIL reset_q got %h exp 0", o_quotient); end
        n_checks++; if (o_remainder !== 32'h0) begin n_fails++; $display("FAIL reset_r got %h exp 0", o_remainder); end
        tick();
        n_checks++; if (o_ready !== 1'b1 || o_done !== 1'b0) begin n_fails++; $display("FAIL reset_start_ignored got ready=%b done=%b exp 1/0", o_ready, o_done); end
    endtask

    task automatic test_iterative();
        int lat, rb; logic [31:0] q, r;
        run_op(32'd100, 32'd7, lat, q, r, rb);
        n_checks++; if (lat != 6) begin n_fails++; $display("FAIL iter_lat got %0d exp 6", lat); end
        n_checks++; if (q !== 32'd14) begin n_fails++; $display("FAIL iter_q got %0d exp 14", q); end
        n_checks++; if (r !== 32'd2) begin n_fails++; $display("FAIL iter_r got %0d exp 2", r); end
        n_checks++; if (rb != 0) begin n_fails++; $display("FAIL iter_ready_busy got %0d high cycles exp 0", rb); end
        tick();
        n_checks++; if (o_done !== 1'b0) begin n_fails++; $display("FAIL iter_done_pulse got %b exp 0", o_done); end
        n_checks++; if (o_quotient !== 32'd14 || o_remainder !== 32'd2) begin n_fails++; $display("FAIL iter_hold got %0d/%0d exp 14/2", o_quotient, o_remainder); end
    endtask

    task automatic test_early_out();
        int lat, rb; logic [31:0] q, r;
        run_op(32'h1234, 32'h0, lat, q, r, rb);
        n_checks++; if (lat != 1 || q !== 32'hFFFF_FFFF || r !== 32'h1234) begin n_fails++; $display("FAIL div_zero got lat=%0d q=%h r=%h exp 1 ffffffff 1234", lat, q, r); end
        run_op(32'd5, 32'd9, lat, q, r, rb);
        n_checks++; if (lat != 1 || q !== 32'd0 || r !== 32'd5) begin n_fails++; $display("FAIL wider_divisor got lat=%0d q=%0d r=%0d exp 1 0 5", lat, q, r); end
        run_op(32'd0, 32'd3, lat, q, r, rb);
        n_checks++; if (lat != 1 || q !== 32'd0 || r !== 32'd0) begin n_fails++; $display("FAIL zero_dividend got lat=%0d q=%0d r=%0d exp 1 0 0", lat, q, r); end
        tick();
    endtask

    task automatic test_extremes();
        int lat, rb; logic [31:0] q, r;
        run_op(32'hFFFF_FFFF, 32'd1, lat, q, r, rb);
        n_checks++; if (lat != 33 || q !== 32'hFFFF_FFFF || r !== 32'd0) begin n_fails++; $display("FAIL max_shift got lat=%0d q=%h r=%h exp 33 ffffffff 0", lat, q, r); end
        run_op(32'd9, 32'd12, lat, q, r, rb);
        n_checks++; if (lat != 2 || q !== 32'd0 || r !== 32'd9) begin n_fails++; $display("FAIL equal_clz got lat=%0d q=%0d r=%0d exp 2 0 9", lat, q, r); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, rb; logic [31:0] q, r;
        run_op(32'd100, 32'd7, lat, q, r, rb);
        n_checks++; if (o_ready !== 1'b1) begin n_fails++; $display("FAIL b2b_ready_in_done got %b exp 1", o_ready); end
        run_op(32'd50, 32'd5, lat, q, r, rb);
        n_checks++; if (lat != 5 || q !== 32'd10 || r !== 32'd0) begin n_fails++; $display("FAIL b2b_second got lat=%0d q=%0d r=%0d exp 5 10 0", lat, q, r); end
        n_checks++; if (rb != 0) begin n_fails++; $display("FAIL b2b_ready_busy got %0d exp 0", rb); end
        tick();
    endtask

    task automatic test_abort();
        int lat, rb, d; logic [31:0] q, r;
        set_ops(32'hFFFF_FFFF, 32'd1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        n_checks++; if (o_ready !== 1'b1 || o_done !== 1'b0) begin n_fails++; $display("FAIL abort_run got ready=%b done=%b exp 1/0", o_ready, o_done); end
        count_dones(40, d);
        n_checks++; if (d != 0) begin n_fails++; $display("FAIL abort_no_done got %0d dones exp 0", d); end
        run_op(32'd100, 32'd7, lat, q, r, rb);
        n_checks++; if (lat != 6 || q !== 32'd14 || r !== 32'd2) begin n_fails++; $display("FAIL abort_recover got lat=%0d q=%0d r=%0d exp 6 14 2", lat, q, r); end
        tick();
        set_ops(32'd100, 32'd7);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        n_checks++; if (o_done !== 1'b0 || o_ready !== 1'b1) begin n_fails++; $display("FAIL abort_final got done=%b ready=%b exp 0/1", o_done, o_ready); end
        count_dones(10, d);
        n_checks++; if (d != 0) begin n_fails++; $display("FAIL abort_final_late got %0d dones exp 0", d); end
        set_ops(32'd0, 32'd3);
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        n_checks++; if (o_done !== 1'b0 || o_ready !== 1'b1) begin n_fails++; $display("FAIL abort_idle_start got done=%b ready=%b exp 0/1", o_done, o_ready); end
    endtask

    task automatic test_rst_mid_run();
        int d;
        set_ops(32'hFFFF_FFFF, 32'd1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        tick();
        i_rst = 1'b1;
        i_start = 1'b1;
        set_ops(32'd100, 32'd7);
        tick();
        i_rst = 1'b0;
        i_start = 1'b0;
        n_checks++; if (o_ready !== 1'b1 || o_done !== 1'b0) begin n_fails++; $display("FAIL rst_mid_ctrl got ready=%b done=%b exp 1/0", o_ready, o_done); end
        n_checks++; if (o_quotient !== 32'h0 || o_remainder !== 32'h0) begin n_fails++; $display("FAIL rst_mid_data got q=%h r=%h exp 0/0", o_quotient, o_remainder); end
        count_dones(40, d);
        n_checks++; if (d != 0) begin n_fails++; $display("FAIL rst_mid_no_done got %0d dones exp 0", d); end
    endtask

    task automatic test_random();
        int lat, rb, exp_lat;
        logic [31:0] a, b, q, r, eq, er;
        for (int n = 0; n < 2000; n++) begin
            a = $urandom >> $urandom_range(0, 31);
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 31) == 0) a = 0;
            if ($urandom_range(0, 31) == 0) b = 0;
            if (b == 0) begin
                eq = 32'hFFFF_FFFF; er = a; exp_lat = 1;
            end else begin
                eq = a / b; er = a % b;
                if (a == 0 || clz(b) < clz(a)) exp_lat = 1;
                else exp_lat = int'(clz(b)) - int'(clz(a)) + 2;
            end
            run_op(a, b, lat, q, r, rb);
            n_checks++;
            if (q !== eq || r !== er || lat != exp_lat) begin
                n_fails++;
                $display("FAIL rand %h/%h got q=%h r=%h lat=%0d exp q=%h r=%h lat=%0d", a, b, q, r, lat, eq, er, exp_lat);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_iterative();
        test_early_out();
        test_extremes();
        test_back_to_back();
        test_abort();
        test_rst_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
